gnr_attractor_ctrl: RTL and testbench

Run controller for a boolean gene-regulatory network built from dual-copy node cells. Each cell holds a tortoise state (s0, which advances on every second start_s0 pulse) and a hare state (s1, which advances on every start_s1 pulse). The controller loads an initial network state and drives reset_nos, start_s0 and start_s1. It compares the two returned state vectors and reports the attractor's transient length (mu) and period (lambda) using Floyd cycle detection. It sits directly between the host-side stream interface and the node array.

---
 rtl/gnr_pkg.sv | 23 ++
 rtl/gnr_state_cmp.sv | 12 +
 rtl/gnr_attractor_ctrl.sv | 131 +++++++++++++
 tb/tb_gnr_attractor_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/gnr_pkg.sv
// rtl/gnr_pkg.sv - shared constants and controller state encoding for the gene-network attractor controller
package gnr_pkg;

  localparam int NUM_NODES = 188;
  localparam int CNT_W     = 32;

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    LOAD    = 4'd1,
    P1_A    = 4'd2,
    P1_B    = 4'd3,
    P1_CMP  = 4'd4,
    P2_STEP = 4'd5,
    P2_CMP  = 4'd6,
    RELOAD  = 4'd7,
    P3_ADV  = 4'd8,
    P3_A    = 4'd9,
    P3_B    = 4'd10,
    P3_CMP  = 4'd11,
    DONE    = 4'd12
  } ctrl_state_t;

endpackage

// File: rtl/gnr_state_cmp.sv
// rtl/gnr_state_cmp.sv - combinational equality reducer for two network state vectors
module gnr_state_cmp #(
  parameter int W = gnr_pkg::NUM_NODES
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic         o_eq
);

  assign o_eq = ~|(i_a ^ i_b);

endmodule

// File: rtl/gnr_attractor_ctrl.sv
// rtl/gnr_attractor_ctrl.sv - Floyd cycle-detection run controller for a dual-copy boolean network
module gnr_attractor_ctrl #(
  parameter int NUM_NODES = gnr_pkg::NUM_NODES,
  parameter int CNT_W     = gnr_pkg::CNT_W,
  parameter int MAX_STEPS = 2**20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NUM_NODES-1:0] in_state,
  output logic                 reset_nos,
  output logic [NUM_NODES-1:0] init_state,
  output logic                 start_s0,
  output logic                 start_s1,
  input  logic [NUM_NODES-1:0] state_s0,
  input  logic [NUM_NODES-1:0] state_s1,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_W-1:0]     mu,
  output logic [CNT_W-1:0]     lambda,
  output logic                 timeout
);
  import gnr_pkg::*;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_STEPS);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  ctrl_state_t      r_state;
  ctrl_state_t      w_state_nxt;
  logic [CNT_W-1:0] r_tcnt;
  logic [CNT_W-1:0] r_lcnt;
  logic [CNT_W-1:0] r_acnt;
  logic [CNT_W-1:0] r_mcnt;
  logic [CNT_W-1:0] w_tcnt_inc;
  logic             r_pass;
  logic             w_eq;
  logic             w_match;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + ONE;
  endfunction

  gnr_state_cmp #(.W(NUM_NODES)) u_cmp (
    .i_a  (state_s0),
    .i_b  (state_s1),
    .o_eq (w_eq)
  );

  // A compare is only meaningful when the mirrored pass flag says s0 finished a whole step.
  assign w_match    = w_eq & r_pass;
  assign w_tcnt_inc = sat_inc(r_tcnt);
  assign in_ready   = (r_state == IDLE) && rst;
  assign out_valid  = (r_state == DONE);

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    reset_nos   = 1'b0;
    start_s0    = 1'b0;
    start_s1    = 1'b0;
    case (r_state)
      IDLE:    if (in_valid) w_state_nxt = LOAD;
      LOAD:    begin reset_nos = 1'b1; w_state_nxt = P1_A; end
      P1_A:    begin start_s0 = 1'b1; start_s1 = 1'b1; w_state_nxt = P1_B; end
      P1_B:    begin start_s0 = 1'b1; start_s1 = 1'b1; w_state_nxt = P1_CMP; end
      P1_CMP: begin
        if (w_match)                     w_state_nxt = P2_STEP;
        else if (w_tcnt_inc == MAX_CNT)  w_state_nxt = DONE;
        else                             w_state_nxt = P1_A;
      end
      P2_STEP: begin start_s1 = 1'b1; w_state_nxt = P2_CMP; end
      P2_CMP:  w_state_nxt = w_match ? RELOAD : P2_STEP;
      RELOAD:  begin reset_nos = 1'b1; w_state_nxt = P3_ADV; end
      P3_ADV: begin
        start_s1 = 1'b1;
        if (r_acnt <= ONE) w_state_nxt = P3_CMP;
      end
      P3_CMP:  w_state_nxt = w_match ? DONE : P3_A;
      P3_A:    begin start_s0 = 1'b1; start_s1 = 1'b1; w_state_nxt = P3_B; end
      P3_B:    begin start_s0 = 1'b1; w_state_nxt = P3_CMP; end
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_tcnt     <= '0;
      r_lcnt     <= '0;
      r_acnt     <= '0;
      r_mcnt     <= '0;
      r_pass     <= 1'b1;
      init_state <= '0;
      mu         <= '0;
      lambda     <= '0;
      timeout    <= 1'b0;
    end else begin
      if (reset_nos)     r_pass <= 1'b1;
      else if (start_s0) r_pass <= ~r_pass;
      case (r_state)
        IDLE: if (in_valid) init_state <= in_state;
        LOAD: begin
          r_tcnt  <= '0;
          r_lcnt  <= '0;
          r_acnt  <= '0;
          r_mcnt  <= '0;
          mu      <= '0;
          lambda  <= '0;
          timeout <= 1'b0;
        end
        P1_CMP: begin
          r_tcnt <= w_tcnt_inc;
          if (!w_match && (w_tcnt_inc == MAX_CNT)) timeout <= 1'b1;
        end
        P2_STEP: r_lcnt <= sat_inc(r_lcnt);
        P2_CMP:  if (w_match) lambda <= r_lcnt;
        RELOAD:  r_acnt <= lambda;
        P3_ADV:  if (r_acnt != '0) r_acnt <= r_acnt - ONE;
        P3_B:    r_mcnt <= sat_inc(r_mcnt);
        P3_CMP:  if (w_match) mu <= r_mcnt;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gnr_attractor_ctrl.sv
// tb/tb_gnr_attractor_ctrl.sv - scoreboard bench with behavioural dual-copy cells around gnr_attractor_ctrl
module tb_gnr_attractor_ctrl;

  localparam int NN = 4;
  localparam int CW = 32;
  localparam int MS = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic [NN-1:0] in_state = '0;
  logic          in_ready, reset_nos, start_s0, start_s1, out_valid, timeout;
  logic [NN-1:0] init_state;
  logic [NN-1:0] state_s0 = '0;
  logic [NN-1:0] state_s1 = '0;
  logic [NN-1:0] pass = '1;
  logic [CW-1:0] mu, lambda;

  gnr_attractor_ctrl #(.NUM_NODES(NN), .CNT_W(CW), .MAX_STEPS(MS)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_state   (in_state),
    .reset_nos  (reset_nos),
    .init_state (init_state),
    .start_s0   (start_s0),
    .start_s1   (start_s1),
    .state_s0   (state_s0),
    .state_s1   (state_s1),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .mu         (mu),
    .lambda     (lambda),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  // Network next-state functions; 3-bit maps keep node 3 at zero.
  int mode = 0;
  function automatic logic [NN-1:0] nf(input logic [NN-1:0] x, input int m);
    logic [2:0] lo;
    lo = x[2:0];
    case (m)
      0: return x;
      1: return {1'b0, lo[1:0], lo[2]};
      2: begin
        if (x == 4'b0000) return 4'b0001;
        return 4'b0011;
      end
      3: return {1'b0, lo + 3'd1};
      default: return x + 4'd1;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reset_nos) begin
      state_s0 <= init_state;
      state_s1 <= init_state;
      pass     <= '1;
    end else begin
      if (start_s0) begin
        state_s0 <= (nf(state_s0, mode) & pass) | (state_s0 & ~pass);
        pass     <= ~pass;
      end
      if (start_s1) state_s1 <= nf(state_s1, mode);
    end
  end

  typedef struct packed {
    logic [CW-1:0] mu;
    logic [CW-1:0] lam;
    logic          to;
  } res_t;

  res_t exp_q[$];
  res_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_rnos   = 0;
  int   s0_cnt   = 0;
  bit   odd_seen = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset_nos) begin
      n_rnos++;
      s0_cnt = 0;
    end else if (start_s0) begin
      s0_cnt++;
    end else if (!start_s1 && s0_cnt[0]) begin
      odd_seen = 1'b1;
    end
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got mu=%0d lambda=%0d timeout=%0b, expected none", mu, lambda, timeout);
      end else begin
        mon_e = exp_q.pop_front();
        check("mu", 64'(mu), 64'(mon_e.mu));
        check("lambda", 64'(lambda), 64'(mon_e.lam));
        check("timeout", 64'(timeout), 64'(mon_e.to));
      end
    end
  end

  task automatic expect_result(input int emu, input int elam, input logic eto);
    res_t e;
    e.mu  = CW'(emu);
    e.lam = CW'(elam);
    e.to  = eto;
    exp_q.push_back(e);
  endtask

  task automatic start(input int m, input logic [NN-1:0] init);
    int k = 0;
    mode = m;
    while (!in_ready && k < 200) begin @(negedge clk); k++; end
    if (!in_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL in_ready_wait: got in_ready=0 after %0d cycles, expected 1", k);
    end
    in_valid = 1'b1;
    in_state = init;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 2000) begin @(negedge clk); k++; end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL result_wait: got %0d pending results after %0d cycles, expected 0", exp_q.size(), k);
      exp_q.delete();
    end
  endtask

  initial begin
    int rn0;
    int k;

    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_strobes", 64'({reset_nos, start_s0, start_s1, out_valid}), 64'd0);
    check("rst_results", 64'({mu, lambda, timeout}), 64'd0);
    check("rst_init_state", 64'(init_state), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_in_ready", 64'(in_ready), 64'd1);

    expect_result(0, 1, 1'b0);
    start(0, 4'b0101);
    wait_drain();

    expect_result(0, 3, 1'b0);
    start(1, 4'b0001);
    wait_drain();

    rn0 = n_rnos;
    expect_result(2, 1, 1'b0);
    start(2, 4'b0000);
    wait_drain();
    check("reset_nos_pulses", 64'(n_rnos - rn0), 64'd2);
    check("s0_pulses_even", 64'(odd_seen), 64'd0);

    expect_result(0, 8, 1'b0);
    start(3, 4'b0000);
    wait_drain();

    expect_result(0, 0, 1'b1);
    start(4, 4'b0000);
    wait_drain();

    out_ready = 1'b0;
    expect_result(0, 3, 1'b0);
    start(1, 4'b0001);
    k = 0;
    while (!out_valid && k < 500) begin @(negedge clk); k++; end
    rn0 = n_rnos;
    in_valid = 1'b1;
    in_state = 4'b0101;
    for (int c = 0; c < 10; c++) begin
      check("hold_out_valid", 64'(out_valid), 64'd1);
      check("hold_mu_lambda", 64'({mu, lambda}), 64'({32'd0, 32'd3}));
      check("hold_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    check("hold_no_reload", 64'(n_rnos - rn0), 64'd0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain();
    @(negedge clk);
    check("post_hs_idle", 64'({in_ready, reset_nos}), 64'({1'b1, 1'b0}));

    start(3, 4'b0000);
    k = 0;
    while (!(start_s1 && !start_s0) && k < 500) begin @(negedge clk); k++; end
    rst = 1'b0;
    @(negedge clk);
    check("abort_outputs", 64'({reset_nos, start_s0, start_s1, out_valid, in_ready}), 64'd0);
    check("abort_results", 64'({mu, lambda, timeout}), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    expect_result(0, 3, 1'b0);
    start(1, 4'b0001);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
